cxu_state_sched: RTL and testbench
==================================

// Module: cxu_state_sched
// PURPOSE
//  Sequencer for the stateful CXU. Accepts one command at a time on the CXU cmd/rsp handshake.
//  Fetches the addressed state context from an external state bank and runs the selected op.
//  Ops are the byte-wise increment, word read/write and clear. Modified state is written back
//  and the 32-bit result is returned. Sits between the CPU CXU port and the state bank; it owns
//  all bank traffic.
// PARAMETERS
//  STATE_W   2048  bits per state context (multiple of 32)
//  NUM_STATE 8     number of contexts in bank; STATE_ID_W=3 fixed by the cmd port
//  CXU_ID    0     id this instance answers to
//  INC_KEY   10    operand value that arms the conditional increment
// PORTS
//  clk                      in  1        clock, all logic on rising edge
//  reset                    in  1        synchronous, active-high
//  cmd_valid                in  1        command present
//  cmd_ready                out 1        1 only in IDLE
//  cmd_payload_function_id  in  3        op select
//  cmd_payload_inputs_0     in  32       operand A / word index in [5:0]
//  cmd_payload_inputs_1     in  32       operand B / write data
//  cmd_payload_state_id     in  3        context select
//  cmd_payload_cxu_id       in  4        target CXU
//  rsp_valid                out 1        response held until rsp_ready
//  rsp_ready                in  1        CPU accepts response
//  rsp_payload_outputs_0    out 32       result
//  bank_rd_en               out 1        read strobe; data returns next cycle
//  bank_addr                out 3        context index (rd and wr)
//  bank_rd_data             in  STATE_W  context read data, valid cycle after bank_rd_en
//  bank_wr_en               out 1        one-cycle write strobe
//  bank_wr_data             out STATE_W  context write data
// BEHAVIOUR
//  Reset: FSM=IDLE. cmd_ready=1, rsp_valid=0, outputs_0=0, bank_rd_en=0, bank_wr_en=0, bank_addr=0.
//  Command latch: accept when cmd_valid&&cmd_ready at cycle T. function_id, inputs, state_id and
//    an error flag are registered at T.
//  Error flag: set if cxu_id!=CXU_ID, state_id>=NUM_STATE or function_id>3.
//  FSM: IDLE -accept-> RD (or RSP if error); RD -> WAIT -> WB -> RSP;
//    RSP -(rsp_ready)-> IDLE.
//  RD: bank_rd_en=1, bank_addr=state_id.
//  WAIT: capture bank_rd_data into ctx register.
//  WB: compute, assert bank_wr_en for 1 cycle if the op writes; bank_addr=state_id; latch result.
//  Latency accept->rsp_valid = 4 cycles (error: 1 cycle). Next accept is no earlier than the
//    cycle after the rsp handshake; no bypass.
//  Ops (w = inputs_0[5:0] mod STATE_W/32):
//   0 INC : if A==INC_KEY && B==INC_KEY, every byte +1 mod 256 (0xFF->0x00, no carry between
//           bytes), written back; else no write. Result = word 0 of post-op context.
//   1 RDW : no write; result = ctx word w.
//   2 WRW : ctx word w <= B, written back; result = old word w.
//   3 CLR : context <= 0, written back; result = 0.
//   error : no bank access; result = 32'hFFFF_FFFF.
//  RSP: rsp_valid=1; outputs_0 stable while !rsp_ready; deassert the cycle after handshake.
//  cmd_ready=0 in all states except IDLE. cmd_valid outside IDLE is ignored, not queued.
//  Reset mid-op: return to IDLE next edge, any pending write/response dropped.
//    bank_wr_en=0 in the reset cycle even when the FSM was in WB.
// STRUCTURE
//  Package cxu_state_pkg: fsm enum {IDLE,RD,WAIT,WB,RSP}, op codes OP_INC..OP_CLR,
//    ERR_RESULT constant, STATE_ID_W.
//  Sub-module cxu_byte_inc (combinational STATE_W-bit per-byte +1) instantiated once.
//  Word select/insert stays inline.
// TESTING
//  1 Reset, INC A=10 B=10 sid=2, ctx all 0x05 -> wr_en at T+3, all bytes 0x06, rsp=0x06060606 at T+4.
//  2 INC A=10 B=9 -> no bank_wr_en; rsp = word 0 of unchanged ctx.
//  3 ctx bytes 0xFF, INC armed -> written ctx all 0x00, rsp=0.
//  4 WRW A=5 B=0xDEADBEEF on ctx word5=0x1234 -> rsp=0x1234; then RDW A=5 -> rsp=0xDEADBEEF.
//  5 sid=8 (NUM_STATE=8), func=6, or cxu_id=1 -> rsp=0xFFFFFFFF at T+1, zero bank strobes.
//  6 rsp_ready low 10 cycles -> rsp held stable, cmd_ready=0.
//    reset asserted in WB -> no wr_en, IDLE next cycle.

Source files
------------

// File: rtl/cxu_state_pkg.sv
// ---------------------------------------------------------------------------
// cxu_state_pkg
// Shared definitions for the stateful CXU sequencer: the sequencer state
// encoding, op codes carried on cmd_payload_function_id, the result returned
// for rejected commands, and the width of the state-context index.
// ---------------------------------------------------------------------------
package cxu_state_pkg;

  localparam int STATE_ID_W = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WB   = 3'd3,
    RSP  = 3'd4
  } fsm_e;

  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_RDW = 3'd1;
  localparam logic [2:0] OP_WRW = 3'd2;
  localparam logic [2:0] OP_CLR = 3'd3;

  localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/cxu_byte_inc.sv
// ---------------------------------------------------------------------------
// cxu_byte_inc
// Combinational per-byte increment of a whole state context. Each byte wraps
// independently (0xFF -> 0x00); no carry propagates into the next byte.
// Ports:
//   i_data  in  STATE_W  context before increment
//   o_data  out STATE_W  context with every byte +1 mod 256
// ---------------------------------------------------------------------------
module cxu_byte_inc #(
  parameter int STATE_W = 2048
) (
  input  logic [STATE_W-1:0] i_data,
  output logic [STATE_W-1:0] o_data
);

  for (genvar gi = 0; gi < STATE_W / 8; gi++) begin : g_byte
    assign o_data[gi*8 +: 8] = i_data[gi*8 +: 8] + 8'd1;
  end

endmodule

// File: rtl/cxu_state_sched.sv
// ---------------------------------------------------------------------------
// cxu_state_sched
// Sequencer for the stateful CXU. Takes one command at a time, fetches the
// addressed context from the external state bank, runs the op (byte
// increment, word read, word write, clear), writes modified state back and
// returns a 32-bit result on the response channel.
// Ports:
//   clk, reset                        clock / synchronous active-high reset
//   cmd_valid, cmd_ready              command handshake (ready only when idle)
//   cmd_payload_function_id [2:0]     op select
//   cmd_payload_inputs_0/1 [31:0]     operand A (word index in [5:0]) / B
//   cmd_payload_state_id [2:0]        context select
//   cmd_payload_cxu_id [3:0]          target CXU
//   rsp_valid, rsp_ready              response handshake
//   rsp_payload_outputs_0 [31:0]      result
//   bank_rd_en, bank_addr             bank read strobe / context index
//   bank_rd_data [STATE_W-1:0]        read data, valid the cycle after rd_en
//   bank_wr_en, bank_wr_data          one-cycle write strobe / write data
// ---------------------------------------------------------------------------
module cxu_state_sched
  import cxu_state_pkg::*;
#(
  parameter int STATE_W   = 2048,
  parameter int NUM_STATE = 8,
  parameter int CXU_ID    = 0,
  parameter int INC_KEY   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_payload_function_id,
  input  logic [31:0]           cmd_payload_inputs_0,
  input  logic [31:0]           cmd_payload_inputs_1,
  input  logic [STATE_ID_W-1:0] cmd_payload_state_id,
  input  logic [3:0]            cmd_payload_cxu_id,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_payload_outputs_0,
  output logic                  bank_rd_en,
  output logic [STATE_ID_W-1:0] bank_addr,
  input  logic [STATE_W-1:0]    bank_rd_data,
  output logic                  bank_wr_en,
  output logic [STATE_W-1:0]    bank_wr_data
);

  localparam int WORDS = STATE_W / 32;

  fsm_e                  r_state;
  logic [2:0]            r_func;
  logic [31:0]           r_a;
  logic [31:0]           r_b;
  logic [STATE_ID_W-1:0] r_sid;
  logic [STATE_W-1:0]    r_ctx;
  logic [31:0]           r_result;

  logic                  w_sid_bad;
  logic                  w_err;
  logic [5:0]            w_widx;
  logic [31:0]           w_old_word;
  logic                  w_armed;
  logic [STATE_W-1:0]    w_inc_ctx;
  logic [STATE_W-1:0]    w_wrw_ctx;
  logic [STATE_W-1:0]    w_new_ctx;
  logic                  w_wr_op;
  logic [31:0]           w_result;

  // With a full-size bank every encodable id is legal, so the range check
  // only exists when the bank is smaller than the id space.
  if (NUM_STATE < (1 << STATE_ID_W)) begin : g_sid_chk
    assign w_sid_bad = (32'(cmd_payload_state_id) >= NUM_STATE);
  end else begin : g_sid_full
    assign w_sid_bad = 1'b0;
  end

  assign w_err = (cmd_payload_cxu_id != 4'(CXU_ID)) || w_sid_bad ||
                 (cmd_payload_function_id > OP_CLR);

  // Word index wraps onto the context size.
  assign w_widx     = 6'(32'(r_a[5:0]) % WORDS);
  assign w_old_word = r_ctx[32*w_widx +: 32];
  assign w_armed    = (r_a == 32'(INC_KEY)) && (r_b == 32'(INC_KEY));

  cxu_byte_inc #(
    .STATE_W (STATE_W)
  ) u_byte_inc (
    .i_data (r_ctx),
    .o_data (w_inc_ctx)
  );

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word_ins
    assign w_wrw_ctx[gi*32 +: 32] = (int'(w_widx) == gi) ? r_b : r_ctx[gi*32 +: 32];
  end

  always_comb begin
    w_new_ctx = r_ctx;
    w_wr_op   = 1'b0;
    w_result  = w_old_word;
    case (r_func)
      OP_INC: begin
        if (w_armed) begin
          w_new_ctx = w_inc_ctx;
          w_wr_op   = 1'b1;
        end
        w_result = w_armed ? w_inc_ctx[31:0] : r_ctx[31:0];
      end
      OP_RDW: w_result = w_old_word;
      OP_WRW: begin
        w_new_ctx = w_wrw_ctx;
        w_wr_op   = 1'b1;
      end
      OP_CLR: begin
        w_new_ctx = '0;
        w_wr_op   = 1'b1;
        w_result  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_func   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sid    <= '0;
      r_ctx    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_func <= cmd_payload_function_id;
            r_a    <= cmd_payload_inputs_0;
            r_b    <= cmd_payload_inputs_1;
            r_sid  <= cmd_payload_state_id;
            if (w_err) begin
              r_result <= ERR_RESULT;
              r_state  <= RSP;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD:   r_state <= WAIT;
        WAIT: begin
          r_ctx   <= bank_rd_data;
          r_state <= WB;
        end
        WB: begin
          r_result <= w_result;
          r_state  <= RSP;
        end
        RSP:     if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready             = (r_state == IDLE);
  assign rsp_valid             = (r_state == RSP);
  assign rsp_payload_outputs_0 = r_result;
  // Strobes are masked by reset so an op interrupted in WB never commits.
  assign bank_rd_en            = (r_state == RD) && !reset;
  assign bank_wr_en            = (r_state == WB) && w_wr_op && !reset;
  assign bank_addr             = ((r_state == RD) || (r_state == WB)) ? r_sid : '0;
  assign bank_wr_data          = w_new_ctx;

endmodule

// File: tb/tb_cxu_state_sched.sv
module tb_cxu_state_sched;

  localparam int SW     = 2048;
  localparam int WORDS  = SW / 32;
  localparam int NBYTES = SW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    fid;
  logic [31:0]   in0, in1;
  logic [2:0]    sid;
  logic [3:0]    cid;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   out0;
  logic          bank_rd_en;
  logic [2:0]    bank_addr;
  logic [SW-1:0] bank_rd_data;
  logic          bank_wr_en;
  logic [SW-1:0] bank_wr_data;

  cxu_state_sched dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .cmd_payload_state_id    (sid),
    .cmd_payload_cxu_id      (cid),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (out0),
    .bank_rd_en              (bank_rd_en),
    .bank_addr               (bank_addr),
    .bank_rd_data            (bank_rd_data),
    .bank_wr_en              (bank_wr_en),
    .bank_wr_data            (bank_wr_data)
  );

  always #5 clk = ~clk;

  // Bank responder and reference copy of the bank
  logic [SW-1:0] tb_mem  [8];
  logic [SW-1:0] ref_mem [8];

  always @(posedge clk) begin
    if (bank_rd_en) bank_rd_data <= tb_mem[bank_addr];
    if (bank_wr_en) tb_mem[bank_addr] <= bank_wr_data;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    int w;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      w = 0;
      for (int i = WORDS - 1; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
      $display("FAIL %s: word %0d got %08h expected %08h", name, w, act[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  // Per-cycle expectations driven by the stimulus, checked on the falling edge
  logic          chk_en = 1'b0;
  logic          e_cmd_ready, e_rsp_valid, e_rd_en, e_wr_en, e_addr_chk;
  logic [2:0]    e_addr;
  logic [31:0]   e_out;
  logic [SW-1:0] e_wr_data;
  logic [31:0]   last_rsp = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk32("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
      chk32("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk32("bank_rd_en", 32'(bank_rd_en), 32'(e_rd_en));
      chk32("bank_wr_en", 32'(bank_wr_en), 32'(e_wr_en));
      if (e_addr_chk) chk32("bank_addr", 32'(bank_addr), 32'(e_addr));
      if (e_rsp_valid) begin
        chk32("rsp_out", out0, e_out);
        last_rsp = out0;
      end
      if (e_wr_en) chk_w("bank_wr_data", bank_wr_data, e_wr_data);
    end
  end

  task automatic set_exp(input logic rdy, input logic rv, input logic rd, input logic wr,
                         input logic ac, input logic [2:0] ad);
    e_cmd_ready = rdy;
    e_rsp_valid = rv;
    e_rd_en     = rd;
    e_wr_en     = wr;
    e_addr_chk  = ac;
    e_addr      = ad;
  endtask

  function automatic logic [SW-1:0] model_inc(input logic [SW-1:0] c);
    logic [SW-1:0] r;
    for (int i = 0; i < NBYTES; i++) r[i*8 +: 8] = 8'((int'(c[i*8 +: 8]) + 1) % 256);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command end to end; the model decides result and bank effect up front.
  task automatic run_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s, input logic [3:0] c, input int hold);
    logic          err, wr;
    logic [31:0]   res;
    logic [SW-1:0] old, nw;
    int            w;
    err = (c != 4'd0) || (f > 3'd3);
    old = ref_mem[s];
    nw  = old;
    wr  = 1'b0;
    w   = int'(a[5:0]) % WORDS;
    res = 32'hFFFF_FFFF;
    if (!err) begin
      case (f)
        3'd0: begin
          if (a == 32'd10 && b == 32'd10) begin
            nw = model_inc(old);
            wr = 1'b1;
          end
          res = nw[31:0];
        end
        3'd1: res = old[w*32 +: 32];
        3'd2: begin
          res = old[w*32 +: 32];
          nw[w*32 +: 32] = b;
          wr = 1'b1;
        end
        default: begin
          res = '0;
          nw  = '0;
          wr  = 1'b1;
        end
      endcase
    end
    e_out = res;
    e_wr_data = nw;
    fid = f; in0 = a; in1 = b; sid = s; cid = c;
    cmd_valid = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    cmd_valid = 1'b0;
    if (!err) begin
      set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, s);
      step();
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      step();
      set_exp(1'b0, 1'b0, 1'b0, wr, 1'b1, s);
      step();
    end
    set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    // A clear command offered while busy must be ignored.
    for (int i = 0; i < hold; i++) begin
      fid = 3'd3; sid = s; cid = 4'd0;
      cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (wr) ref_mem[s] = nw;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    $display("cmd f=%0d a=%08h b=%08h sid=%0d cxu=%0d -> rsp %08h (exp %08h)", f, a, b, s, c, last_rsp, res);
  endtask

  initial begin
    logic [SW-1:0] v;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < WORDS; w++)
        tb_mem[s][w*32 +: 32] = 32'(32'h1000_0000 * s + 32'h0001_0003 * w + 7);
    tb_mem[2] = {NBYTES{8'h05}};
    tb_mem[4] = {NBYTES{8'hFF}};
    tb_mem[1][5*32 +: 32] = 32'h0000_1234;
    for (int s = 0; s < 8; s++) ref_mem[s] = tb_mem[s];

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    fid = '0; in0 = '0; in1 = '0; sid = '0; cid = '0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    chk32("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk32("rst_out", out0, 32'd0);
    chk32("rst_rd_en", 32'(bank_rd_en), 32'd0);
    chk32("rst_wr_en", 32'(bank_wr_en), 32'd0);
    chk32("rst_addr", 32'(bank_addr), 32'd0);
    step();
    reset = 1'b0;
    chk_en = 1'b1;

    run_cmd(3'd0, 32'd10, 32'd10, 3'd2, 4'd0, 0);
    chk32("t1_rsp_lit", last_rsp, 32'h0606_0606);
    v = {NBYTES{8'h06}};
    chk_w("t1_mem_lit", tb_mem[2], v);

    run_cmd(3'd0, 32'd10, 32'd9, 3'd0, 4'd0, 0);
    chk32("t2_rsp_lit", last_rsp, 32'h0000_0007);

    run_cmd(3'd0, 32'd10, 32'd10, 3'd4, 4'd0, 0);
    chk32("t3_rsp_lit", last_rsp, 32'h0);
    v = '0;
    chk_w("t3_mem_lit", tb_mem[4], v);

    run_cmd(3'd2, 32'd5, 32'hDEAD_BEEF, 3'd1, 4'd0, 0);
    chk32("t4_wrw_lit", last_rsp, 32'h0000_1234);
    run_cmd(3'd1, 32'd5, 32'd0, 3'd1, 4'd0, 0);
    chk32("t4_rdw_lit", last_rsp, 32'hDEAD_BEEF);
    run_cmd(3'd1, 32'h45, 32'd0, 3'd1, 4'd0, 0);
    chk32("t4_rdw_wrap_lit", last_rsp, 32'hDEAD_BEEF);
    run_cmd(3'd2, 32'd63, 32'hCAFE_F00D, 3'd1, 4'd0, 0);
    chk32("t4_wrw63_lit", last_rsp, 32'h103F_00C4);

    run_cmd(3'd6, 32'd0, 32'd0, 3'd0, 4'd0, 0);
    chk32("t5_func6_lit", last_rsp, 32'hFFFF_FFFF);
    run_cmd(3'd4, 32'd10, 32'd10, 3'd2, 4'd0, 0);
    run_cmd(3'd3, 32'd0, 32'd0, 3'd1, 4'd1, 0);
    chk32("t5_cxu1_lit", last_rsp, 32'hFFFF_FFFF);

    run_cmd(3'd3, 32'd0, 32'd0, 3'd6, 4'd0, 0);
    v = '0;
    chk_w("clr_mem_lit", tb_mem[6], v);

    run_cmd(3'd1, 32'd5, 32'd0, 3'd1, 4'd0, 10);
    chk32("t6_hold_lit", last_rsp, 32'hDEAD_BEEF);

    // Reset while the write-back of a clear is pending
    fid = 3'd3; in0 = '0; in1 = '0; sid = 3'd3; cid = 4'd0;
    cmd_valid = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    cmd_valid = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
    step();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk32("rst_wb_wr_en", 32'(bank_wr_en), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk32("rst_wb_cmd_ready", 32'(cmd_ready), 32'd1);
    chk32("rst_wb_rsp_valid", 32'(rsp_valid), 32'd0);
    chk32("rst_wb_out", out0, 32'd0);
    step();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk_en = 1'b1;
    run_cmd(3'd1, 32'd0, 32'd0, 3'd3, 4'd0, 0);
    chk32("rst_wb_ctx_lit", last_rsp, 32'h3000_0007);

    for (int s = 0; s < 8; s++) chk_w("final_bank", tb_mem[s], ref_mem[s]);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
